// File: rtl/fp_add_sched_pkg.sv
// Shared types and constants for the fp_add_sched adder scheduler.
package fp_add_sched_pkg;

   localparam int unsigned DEF_NREQ   = 4;
   localparam int unsigned DEF_DW     = 32;
   localparam int unsigned PERF_CNT_W = 16;

   typedef logic [$clog2(DEF_NREQ)-1:0] req_id_t;
   typedef logic [31:0]                 fp32_t;

endpackage

// File: rtl/fp_add_sched_tagfifo.sv
// In-flight requester-ID FIFO; head entry names the owner of the next adder result.
module fp_add_sched_tagfifo
   import fp_add_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDW   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [IDW-1:0]           din,
   output logic [IDW-1:0]           dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [IDW-1:0] mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fp_add_sched.sv
// Round-robin sharing of one in-order float adder among NREQ requesters.
// Define FP_ADD_SCHED_PERF_EN to add per-requester saturating issue counters.
module fp_add_sched
   import fp_add_sched_pkg::*;
#(
   parameter int unsigned NREQ         = DEF_NREQ,
   parameter int unsigned MAX_INFLIGHT = 8,
   parameter int unsigned DW           = DEF_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*DW-1:0]   req_a,
   input  logic [NREQ*DW-1:0]   req_b,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [DW-1:0]        rsp_c,
   output logic [DW-1:0]        add_a,
   output logic [DW-1:0]        add_b,
   output logic                 add_a_valid,
   output logic                 add_b_valid,
   input  logic                 add_a_ready,
   input  logic                 add_b_ready,
   input  logic [DW-1:0]        add_c,
   input  logic                 add_c_valid,
   output logic                 add_c_ready,
   output logic                 busy
`ifdef FP_ADD_SCHED_PERF_EN
   ,
   output logic [NREQ*PERF_CNT_W-1:0] perf_issue_cnt
`endif
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(MAX_INFLIGHT) + 1;

   logic [DW-1:0]  a_arr [NREQ];
   logic [DW-1:0]  b_arr [NREQ];
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] cand;
   logic [IDW-1:0] head;
   logic           any_valid;
   logic           can_issue;
   logic           fifo_full;
   logic           fifo_empty;
   logic           pop;
   logic [CW-1:0]  fifo_count;
   logic [DW-1:0]  a_q;
   logic [DW-1:0]  b_q;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*DW +: DW];
      assign b_arr[i] = req_b[i*DW +: DW];
   end

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      any_valid = 1'b0;
      grant     = rr_ptr;
      cand      = rr_ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(rr_ptr) + k) % NREQ);
         if (!any_valid && req_valid[cand]) begin
            any_valid = 1'b1;
            grant     = cand;
         end
      end
   end

   // Full check uses the registered count, so a same-cycle pop does not free a slot.
   assign can_issue   = any_valid && add_a_ready && add_b_ready && !fifo_full && !rst;
   assign add_a_valid = can_issue;
   assign add_b_valid = can_issue;
   assign req_ready   = can_issue ? (NREQ'(1) << grant) : '0;
   assign add_a       = can_issue ? a_arr[grant] : a_q;
   assign add_b       = can_issue ? b_arr[grant] : b_q;

   // Results come back in issue order; the FIFO head names their owner.
   assign rsp_valid   = (add_c_valid && !fifo_empty && !rst) ? (NREQ'(1) << head) : '0;
   assign rsp_c       = add_c;
   assign add_c_ready = rsp_ready[head] && !fifo_empty && !rst;
   assign pop         = add_c_valid && add_c_ready;
   assign busy        = (fifo_count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
         a_q    <= '0;
         b_q    <= '0;
      end else if (can_issue) begin
         rr_ptr <= IDW'((32'(grant) + 1) % NREQ);
         a_q    <= a_arr[grant];
         b_q    <= b_arr[grant];
      end
   end

   fp_add_sched_tagfifo #(
      .DEPTH (MAX_INFLIGHT),
      .IDW   (IDW)
   ) u_tagfifo (
      .clk   (clk),
      .rst   (rst),
      .push  (can_issue),
      .pop   (pop),
      .din   (grant),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef FP_ADD_SCHED_PERF_EN
   logic [PERF_CNT_W-1:0] perf_cnt [NREQ];

   // Saturating per-requester issue counters.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (rst) begin
            perf_cnt[i] <= '0;
         end else if (can_issue && (grant == IDW'(i)) && (perf_cnt[i] != '1)) begin
            perf_cnt[i] <= perf_cnt[i] + PERF_CNT_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_perf
      assign perf_issue_cnt[i*PERF_CNT_W +: PERF_CNT_W] = perf_cnt[i];
   end
`endif

endmodule
